// File: rtl/sb_pkg.sv
// Shared definitions for the register scoreboard: default geometry and small
// helpers for counter limits and writeback-port slicing.
package sb_pkg;

  localparam int SB_ADDR_W    = 5;
  localparam int SB_REG_COUNT = 32;

  // Largest value a pending counter of the given width may hold.
  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  // Low bit of writeback port 'port' inside the flattened wb_dst bus.
  function automatic int wb_lo(input int port, input int addr_w);
    return port * addr_w;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One per-register in-flight write counter: adds the issue increment, removes
// writebacks/kills, clamps at both ends and flags any clamp it had to apply.
module sb_entry
  import sb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [CNT_W+1:0] dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [CNT_W+1:0] MAX_W = (CNT_W + 2)'(cnt_max(CNT_W));

  logic [CNT_W+1:0] up;
  logic [CNT_W+1:0] diff;

  // Work two bits wider than the counter so that both a negative result and a
  // result above the maximum are visible before clamping.
  always_comb begin
    up        = {2'b00, count} + {{(CNT_W + 1){1'b0}}, inc};
    diff      = up - dec;
    underflow = dec > up;
    overflow  = !underflow && (diff > MAX_W);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (underflow) begin
      count <= '0;
    end else if (overflow) begin
      count <= MAX_W[CNT_W-1:0];
    end else begin
      count <= diff[CNT_W-1:0];
    end
  end

  assign nonzero = |count;

endmodule

// File: rtl/reg_scoreboard.sv
// Decode-stage register scoreboard: per-register in-flight write counters,
// RAW/saturation issue hazards, a total-outstanding counter and a sticky error.
module reg_scoreboard
  import sb_pkg::*;
#(
  parameter int REG_COUNT = SB_REG_COUNT,
  parameter int ADDR_W    = SB_ADDR_W,
  parameter int WB_PORTS  = 2,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1,
  parameter int OUT_W     = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic                       issue_wr,
  input  logic [ADDR_W-1:0]          issue_dst,
  input  logic [ADDR_W-1:0]          issue_rs,
  input  logic [ADDR_W-1:0]          issue_rt,
  input  logic                       issue_rs_used,
  input  logic                       issue_rt_used,
  input  logic                       hold,
  output logic                       issue_stall,
  output logic                       issue_accept,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*ADDR_W-1:0] wb_dst,
  input  logic                       kill_valid,
  input  logic [ADDR_W-1:0]          kill_dst,
  output logic [REG_COUNT-1:0]       pending,
  output logic [OUT_W-1:0]           outstanding,
  output logic                       idle,
  output logic                       err
);

  localparam int               DEC_W    = CNT_W + 2;
  localparam int               IDX_N    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(cnt_max(CNT_W));

  // Register 0 is never tracked, so the per-register arrays start at 1.
  logic [CNT_W-1:0]     cnt [1:REG_COUNT-1];
  logic [DEC_W-1:0]     dec [1:REG_COUNT-1];
  logic [REG_COUNT-1:1] inc;
  logic [REG_COUNT-1:1] nz;
  logic [REG_COUNT-1:1] uf;
  logic [REG_COUNT-1:1] of;
  logic [IDX_N-1:0]     busy;
  logic [IDX_N-1:0]     sat;

  logic             rs_hit;
  logic             rt_hit;
  logic             write_block;
  logic             out_full;
  logic             dst_tracked;
  logic             tot_inc;
  logic [OUT_W-1:0] tot_dec;
  logic [OUT_W-1:0] up_out;
  logic [OUT_W-1:0] out_next;
  logic             out_uf;

  // Decrements per register, and the hazard view of each register: with
  // bypass a register whose last writes retire this cycle no longer blocks.
  always_comb begin
    busy = '0;
    sat  = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      dec[r] = '0;
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid[p] && (wb_dst[wb_lo(p, ADDR_W) +: ADDR_W] == ADDR_W'(r))) begin
          dec[r] = dec[r] + DEC_W'(1);
        end
      end
      if (kill_valid && (kill_dst == ADDR_W'(r))) begin
        dec[r] = dec[r] + DEC_W'(1);
      end
      busy[r] = (WB_BYPASS != 0) ? ({2'b00, cnt[r]} > dec[r]) : (cnt[r] != '0);
      sat[r]  = (cnt[r] == CNT_FULL);
    end
  end

  // Issue decision; a write is refused while its counter or the global total
  // is full, regardless of any writeback in the same cycle.
  always_comb begin
    out_full     = (outstanding == '1);
    rs_hit       = issue_rs_used && (issue_rs != '0) && busy[issue_rs];
    rt_hit       = issue_rt_used && (issue_rt != '0) && busy[issue_rt];
    write_block  = issue_wr && (((issue_dst != '0) && sat[issue_dst]) || out_full);
    issue_stall  = issue_valid && (rs_hit || rt_hit || write_block);
    issue_accept = issue_valid && !issue_stall && !hold;
    inc          = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      inc[r] = issue_accept && issue_wr && (issue_dst == ADDR_W'(r));
    end
  end

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_entry
    sb_entry #(
      .CNT_W(CNT_W)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc[r]),
      .dec      (dec[r]),
      .count    (cnt[r]),
      .nonzero  (nz[r]),
      .underflow(uf[r]),
      .overflow (of[r])
    );
  end

  // Total in-flight writes; only events on tracked registers take part.
  always_comb begin
    dst_tracked = (issue_dst != '0) && (int'(issue_dst) < REG_COUNT);
    tot_inc     = issue_accept && issue_wr && dst_tracked;
    tot_dec     = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      tot_dec = tot_dec + OUT_W'(dec[r]);
    end
    up_out   = outstanding + OUT_W'(tot_inc);
    out_uf   = tot_dec > up_out;
    out_next = up_out - tot_dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      outstanding <= out_uf ? '0 : out_next;
      err         <= err || (|uf) || (|of) || out_uf;
    end
  end

  assign pending = {nz, 1'b0};
  assign idle    = (outstanding == '0);

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios followed by random
// traffic, all compared against a count-per-register reference model.
module tb_reg_scoreboard;

  localparam int REG_COUNT = 32;
  localparam int ADDR_W    = 5;
  localparam int WB_PORTS  = 2;
  localparam int CNT_W     = 2;
  localparam int WB_BYPASS = 1;
  localparam int OUT_W     = 6;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int OMAX      = (1 << OUT_W) - 1;

  logic                       clk;
  logic                       reset;
  logic                       issue_valid;
  logic                       issue_wr;
  logic [ADDR_W-1:0]          issue_dst;
  logic [ADDR_W-1:0]          issue_rs;
  logic [ADDR_W-1:0]          issue_rt;
  logic                       issue_rs_used;
  logic                       issue_rt_used;
  logic                       hold;
  logic                       issue_stall;
  logic                       issue_accept;
  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*ADDR_W-1:0] wb_dst;
  logic                       kill_valid;
  logic [ADDR_W-1:0]          kill_dst;
  logic [REG_COUNT-1:0]       pending;
  logic [OUT_W-1:0]           outstanding;
  logic                       idle;
  logic                       err;

  int   total = 0;
  int   bad   = 0;
  int   m_cnt [REG_COUNT];
  int   m_out;
  bit   m_err;
  logic s_stall;
  logic s_acc;

  reg_scoreboard #(
    .REG_COUNT(REG_COUNT),
    .ADDR_W   (ADDR_W),
    .WB_PORTS (WB_PORTS),
    .CNT_W    (CNT_W),
    .WB_BYPASS(WB_BYPASS),
    .OUT_W    (OUT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_wr     (issue_wr),
    .issue_dst    (issue_dst),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_rs_used(issue_rs_used),
    .issue_rt_used(issue_rt_used),
    .hold         (hold),
    .issue_stall  (issue_stall),
    .issue_accept (issue_accept),
    .wb_valid     (wb_valid),
    .wb_dst       (wb_dst),
    .kill_valid   (kill_valid),
    .kill_dst     (kill_dst),
    .pending      (pending),
    .outstanding  (outstanding),
    .idle         (idle),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of writebacks plus kills aimed at register r this cycle.
  function automatic int m_decs(input int r);
    int n = 0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && int'(wb_dst[p*ADDR_W +: ADDR_W]) == r) n++;
    end
    if (kill_valid && int'(kill_dst) == r) n++;
    return n;
  endfunction

  function automatic bit m_busy(input int r);
    int eff;
    if (r == 0) return 1'b0;
    eff = m_cnt[r] - ((WB_BYPASS != 0) ? m_decs(r) : 0);
    return eff > 0;
  endfunction

  function automatic bit m_stall();
    bit raw;
    bit full;
    int d = int'(issue_dst);
    raw  = (issue_rs_used && m_busy(int'(issue_rs))) || (issue_rt_used && m_busy(int'(issue_rt)));
    full = issue_wr && ((d != 0 && m_cnt[d] == CMAX) || m_out == OMAX);
    return issue_valid && (raw || full);
  endfunction

  function automatic bit m_accept();
    return issue_valid && !m_stall() && !hold;
  endfunction

  task automatic model_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_out = 0;
    m_err = 1'b0;
  endtask

  task automatic model_update();
    bit acc = m_accept();
    int tinc = 0;
    int tdec = 0;
    for (int r = 1; r < REG_COUNT; r++) begin
      int d = m_decs(r);
      int i = (acc && issue_wr && int'(issue_dst) == r) ? 1 : 0;
      int n = m_cnt[r] + i - d;
      tinc += i;
      tdec += d;
      if (n < 0) begin n = 0; m_err = 1'b1; end
      if (n > CMAX) begin n = CMAX; m_err = 1'b1; end
      m_cnt[r] = n;
    end
    m_out = m_out + tinc - tdec;
    if (m_out < 0) begin m_out = 0; m_err = 1'b1; end
  endtask

  task automatic check_output(input string tag);
    logic [REG_COUNT-1:0] exp_pend = '0;
    for (int r = 0; r < REG_COUNT; r++) exp_pend[r] = (m_cnt[r] != 0);
    check_val({tag, ".pending"}, 64'(pending), 64'(exp_pend));
    check_val({tag, ".outstanding"}, 64'(outstanding), 64'(m_out));
    check_val({tag, ".idle"}, 64'(idle), 64'(m_out == 0));
    check_val({tag, ".err"}, 64'(err), 64'(m_err));
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_wr = 0; issue_dst = '0; issue_rs = '0; issue_rt = '0;
    issue_rs_used = 0; issue_rt_used = 0; hold = 0;
    wb_valid = '0; wb_dst = '0; kill_valid = 0; kill_dst = '0;
  endtask

  task automatic apply_stimulus(input bit v, input bit wr, input int dst, input int rs, input int rt,
                                input bit rsu, input bit rtu, input bit hld);
    issue_valid = v; issue_wr = wr; issue_dst = ADDR_W'(dst);
    issue_rs = ADDR_W'(rs); issue_rt = ADDR_W'(rt);
    issue_rs_used = rsu; issue_rt_used = rtu; hold = hld;
  endtask

  task automatic set_wb(input int p, input int d);
    wb_valid[p] = 1'b1;
    wb_dst[p*ADDR_W +: ADDR_W] = ADDR_W'(d);
  endtask

  // Inputs are set just after a rising edge; the combinational decision is
  // checked at the falling edge and the registered state after the next rise.
  task automatic step(input string tag);
    @(negedge clk);
    s_stall = issue_stall;
    s_acc   = issue_accept;
    check_val({tag, ".stall"}, 64'(issue_stall), 64'(m_stall()));
    check_val({tag, ".accept"}, 64'(issue_accept), 64'(m_accept()));
    @(posedge clk);
    #1;
    model_update();
    check_output(tag);
  endtask

  task automatic reset_pulse(input string tag);
    clear_inputs();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_output(tag);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int avail [REG_COUNT];
    clear_inputs();
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] mid-run reset");
    apply_stimulus(1, 1, 3, 0, 0, 0, 0, 0); step("acc_r3");
    apply_stimulus(1, 1, 7, 0, 0, 0, 0, 0); step("acc_r7");
    check_val("pre_rst_outstanding", 64'(outstanding), 64'd2);
    reset_pulse("mid_rst");
    set_wb(0, 3); step("stale_wb");
    check_val("stale_wb_err", 64'(err), 64'd1);
    reset_pulse("clr_err");

    $display("[TB] RAW stall and bypass");
    apply_stimulus(1, 1, 5, 0, 0, 0, 0, 0); step("raw_acc_r5");
    apply_stimulus(1, 0, 0, 5, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step("raw_wait");
      check_val("raw_stall_held", 64'(s_stall), 64'd1);
    end
    set_wb(1, 5); step("raw_bypass");
    check_val("raw_bypass_accept", 64'(s_acc), 64'd1);
    clear_inputs();

    $display("[TB] WAW saturation");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 1, 9, 0, 0, 0, 0, 0); step("waw_acc");
    end
    check_val("waw_out3", 64'(outstanding), 64'd3);
    set_wb(0, 9); step("waw_sat_wb");
    check_val("waw_sat_stall", 64'(s_stall), 64'd1);
    clear_inputs();
    apply_stimulus(1, 1, 9, 0, 0, 0, 0, 0); step("waw_fourth");
    check_val("waw_fourth_accept", 64'(s_acc), 64'd1);
    check_val("waw_fourth_out", 64'(outstanding), 64'd3);
    clear_inputs();
    set_wb(0, 9); set_wb(1, 9); step("waw_drain2");
    clear_inputs();
    set_wb(0, 9); step("waw_drain1");
    clear_inputs();
    check_val("waw_idle", 64'(idle), 64'd1);

    $display("[TB] simultaneous events");
    apply_stimulus(1, 1, 4, 0, 0, 0, 0, 0); step("sim_acc_a");
    step("sim_acc_b");
    set_wb(0, 4); set_wb(1, 4); step("sim_net");
    check_val("sim_net_pend", 64'(pending[4]), 64'd1);
    check_val("sim_net_err", 64'(err), 64'd0);
    clear_inputs();
    set_wb(0, 4); set_wb(1, 4); step("sim_under");
    check_val("sim_under_pend", 64'(pending[4]), 64'd0);
    check_val("sim_under_err", 64'(err), 64'd1);
    reset_pulse("sim_rst");

    $display("[TB] kill and hold");
    apply_stimulus(1, 1, 12, 0, 0, 0, 0, 0); step("kill_acc");
    clear_inputs();
    kill_valid = 1'b1; kill_dst = ADDR_W'(12); step("kill");
    check_val("kill_pend", 64'(pending[12]), 64'd0);
    clear_inputs();
    apply_stimulus(1, 1, 13, 1, 2, 1, 1, 1); step("hold");
    check_val("hold_accept", 64'(s_acc), 64'd0);
    check_val("hold_stall", 64'(s_stall), 64'd0);
    check_val("hold_pend", 64'(pending[13]), 64'd0);
    clear_inputs();

    $display("[TB] register 0");
    apply_stimulus(1, 1, 6, 0, 0, 0, 0, 0); step("r0_acc_r6");
    apply_stimulus(1, 1, 0, 0, 0, 1, 1, 0); step("r0_issue");
    check_val("r0_stall", 64'(s_stall), 64'd0);
    check_val("r0_accept", 64'(s_acc), 64'd1);
    check_val("r0_pend", 64'(pending[0]), 64'd0);
    check_val("r0_out", 64'(outstanding), 64'd1);
    clear_inputs();
    set_wb(0, 0); step("r0_wb");
    check_val("r0_wb_err", 64'(err), 64'd0);
    clear_inputs();
    set_wb(1, 6); step("r0_drain");
    clear_inputs();

    $display("[TB] random traffic");
    reset_pulse("rand_rst");
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      foreach (m_cnt[r]) avail[r] = m_cnt[r];
      for (int p = 0; p < WB_PORTS; p++) begin
        int r = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1 && (r == 0 || avail[r] > 0)) begin
          set_wb(p, r);
          if (r != 0) avail[r]--;
        end
      end
      begin
        int k = $urandom_range(1, 7);
        if ($urandom_range(0, 7) == 0 && avail[k] > 0) begin
          kill_valid = 1'b1;
          kill_dst   = ADDR_W'(k);
        end
      end
      step("rand");
    end
    clear_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
